// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter:
// FSM state encoding, line-format encodings and legal parameter limits.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // parity_mode encodings; anything else means no parity bit
    localparam logic [2:0] PAR_NONE  = 3'b000;
    localparam logic [2:0] PAR_ODD   = 3'b001;
    localparam logic [2:0] PAR_EVEN  = 3'b010;
    localparam logic [2:0] PAR_MARK  = 3'b011;
    localparam logic [2:0] PAR_SPACE = 3'b100;

    // stop_cfg encodings; 2'b11 behaves as two stop bits
    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    // legal parameter ranges
    localparam int DATA_W_MIN     = 5;
    localparam int DATA_W_LIM     = 9;
    localparam int OVS_MIN        = 8;
    localparam int OVS_MAX        = 32;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 64;

endpackage

// File: rtl/uart_tx_param_if.sv
// Bundle of the transmitter's host-side, configuration and line signals.
// master = the host/bench side, slave = the transmitter.
interface uart_tx_param_if #(
    parameter int DATA_W_MAX = 9,
    parameter int FIFO_DEPTH = 8
);
    import uart_pkg::*;

    logic                          tick;
    logic                          wr_en;
    logic [DATA_W_MAX-1:0]         wr_data;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic [3:0]                    data_bits;
    logic [1:0]                    stop_cfg;
    logic [2:0]                    parity_mode;
    logic                          cts_n;
    logic                          send_break;
    logic                          tx;
    logic                          tx_busy;
    logic                          tx_done;

    modport master (
        output tick, wr_en, wr_data, data_bits, stop_cfg, parity_mode, cts_n, send_break,
        input  fifo_full, fifo_empty, fifo_level, tx, tx_busy, tx_done
    );

    modport slave (
        input  tick, wr_en, wr_data, data_bits, stop_cfg, parity_mode, cts_n, send_break,
        output fifo_full, fifo_empty, fifo_level, tx, tx_busy, tx_done
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO holding characters waiting to be sent.
// A push while full is dropped regardless of a simultaneous pop.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             push, pop;

    assign full_o    = (level_q == FULL_LVL);
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q];

    // storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    // pointers and occupancy count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-fed framing FSM with programmable
// length, parity and stop bits, CTS flow control and break generation.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_param_if.slave bus
);
    localparam int BRK_TICKS = (DATA_W_MAX + 3) * OVS;
    localparam int CNT_W     = $clog2(BRK_TICKS);
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] BRK_END = CNT_W'(BRK_TICKS - 1);

    // Clamp the requested character length into the supported range.
    function automatic logic [3:0] sat_bits(input logic [3:0] req);
        logic [3:0] r;
        if (req < 4'(DATA_W_MIN))      r = 4'(DATA_W_MIN);
        else if (req > 4'(DATA_W_MAX)) r = 4'(DATA_W_MAX);
        else                           r = req;
        return r;
    endfunction

    // Parity over the first n data bits only.
    function automatic logic parity_of(input logic [DATA_W_MAX-1:0] d,
                                       input logic [3:0] n,
                                       input logic [2:0] mode);
        logic x, p;
        x = 1'b0;
        for (int i = 0; i < DATA_W_MAX; i++) begin
            if (i < int'(n)) x = x ^ d[i];
        end
        case (mode)
            PAR_ODD:  p = ~x;
            PAR_EVEN: p = x;
            PAR_MARK: p = 1'b1;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

    // Last tick-count value of the stop period.
    function automatic logic [CNT_W-1:0] stop_end(input logic [1:0] cfg);
        logic [CNT_W-1:0] e;
        case (cfg)
            STOP_1:   e = CNT_W'(OVS - 1);
            STOP_1P5: e = CNT_W'(3 * OVS / 2 - 1);
            default:  e = CNT_W'(2 * OVS - 1);
        endcase
        return e;
    endfunction

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [3:0]            nbits_q, nbits_d;
    logic [DATA_W_MAX-1:0] shift_q, shift_d;
    logic [1:0]            stop_q, stop_d;
    logic                  has_par_q, has_par_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  pop, launch, bit_end;
    logic [DATA_W_MAX-1:0] head;
    logic [3:0]            cfg_bits;
    logic                  fifo_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_W_MAX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (bus.wr_en),
        .wr_data_i (bus.wr_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (bus.fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (bus.fifo_level)
    );

    assign bus.fifo_empty = fifo_empty;
    assign bus.tx         = tx_q;
    assign bus.tx_busy    = (state_q != ST_IDLE);
    assign bus.tx_done    = done_q;
    assign cfg_bits       = sat_bits(bus.data_bits);

    // Next-state logic; every move happens on a tick. The launch decision is
    // shared by IDLE and the end of STOP so frames can run back to back.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        nbits_d   = nbits_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        has_par_d = has_par_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        launch    = 1'b0;
        bit_end   = (cnt_q == BIT_END);
        if (bus.tick) begin
            case (state_q)
                ST_IDLE: launch = 1'b1;
                ST_START: begin
                    if (bit_end) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                    end else cnt_d = cnt_q + 1'b1;
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_d = '0;
                        if (bit_q == nbits_q - 4'd1) begin
                            state_d = has_par_q ? ST_PARITY : ST_STOP;
                            tx_d    = has_par_q ? par_bit_q : 1'b1;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            shift_d = shift_q >> 1;
                            tx_d    = shift_q[1];
                        end
                    end else cnt_d = cnt_q + 1'b1;
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_d = ST_STOP;
                        cnt_d   = '0;
                        tx_d    = 1'b1;
                    end else cnt_d = cnt_q + 1'b1;
                end
                ST_STOP: begin
                    if (cnt_q == stop_end(stop_q)) begin
                        launch = 1'b1;
                        done_d = 1'b1;
                    end else cnt_d = cnt_q + 1'b1;
                end
                ST_BREAK: begin
                    // counter saturates once the minimum break length is met
                    if (cnt_q == BRK_END) begin
                        if (!bus.send_break) begin
                            state_d = ST_STOP;
                            stop_d  = STOP_1;
                            cnt_d   = '0;
                            tx_d    = 1'b1;
                        end
                    end else cnt_d = cnt_q + 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end
            endcase
            if (launch) begin
                cnt_d = '0;
                if (bus.send_break) begin
                    state_d = ST_BREAK;
                    tx_d    = 1'b0;
                end else if (!fifo_empty && !bus.cts_n) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    pop       = 1'b1;
                    shift_d   = head;
                    nbits_d   = cfg_bits;
                    stop_d    = bus.stop_cfg;
                    has_par_d = (bus.parity_mode >= PAR_ODD) && (bus.parity_mode <= PAR_SPACE);
                    par_bit_d = parity_of(head, cfg_bits, bus.parity_mode);
                end else begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end
            end
        end
    end

    // Control state: FSM, counters and the registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Per-frame character and format, latched when a frame launches.
    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        nbits_q   <= nbits_d;
        stop_q    <= stop_d;
        has_par_q <= has_par_d;
        par_bit_q <= par_bit_d;
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: directed scenarios plus randomised frames, with
// the line sampled once per tick and compared against a per-tick model.
module tb_uart_tx_param;
    localparam int DW    = 9;
    localparam int OVS   = 16;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_W_MAX(DW), .FIFO_DEPTH(DEPTH)) m();

    uart_tx_param #(.DATA_W_MAX(DW), .OVS(OVS), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m.slave)
    );

    int   total = 0;
    int   bad   = 0;
    int   gap   = 0;
    int   tick_cnt = 0;
    int   done_cnt = 0;
    int   obs_base = 0;
    int   done_base = 0;
    logic obs[$];
    logic exp_q[$];

    // tick generator and line monitor: record tx once per tick, after the edge
    always @(negedge clk) begin
        if (m.tick === 1'b1) begin
            obs.push_back(m.tx);
            tick_cnt++;
        end
        if (m.tx_done === 1'b1) done_cnt++;
        if (gap == 0) begin
            m.tick = 1'b1;
            gap = $urandom_range(1, 2);
        end else begin
            m.tick = 1'b0;
            gap--;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: timed out waiting for the DUT", tag);
    endtask

    task automatic push(input logic [DW-1:0] d);
        m.wr_en   = 1'b1;
        m.wr_data = d;
        step();
        m.wr_en   = 1'b0;
    endtask

    task automatic cfg(input int db, input int st, input int pm);
        m.data_bits   = 4'(db);
        m.stop_cfg    = 2'(st);
        m.parity_mode = 3'(pm);
    endtask

    task automatic mark();
        obs_base  = obs.size();
        done_base = done_cnt;
        exp_q.delete();
    endtask

    task automatic wait_ticks(input int n);
        int target, g;
        target = tick_cnt + n;
        g = 0;
        while (tick_cnt < target && g < n * 4 + 20) begin step(); g++; end
        if (tick_cnt < target) timeout("wait_ticks");
    endtask

    task automatic wait_busy();
        int g;
        g = 0;
        while (m.tx_busy !== 1'b1 && g < 200) begin step(); g++; end
        if (m.tx_busy !== 1'b1) timeout("wait_busy");
    endtask

    task automatic wait_done(input int n);
        int g;
        g = 0;
        while (!(done_cnt >= done_base + n && m.tx_busy === 1'b0) && g < 20000) begin step(); g++; end
        if (g >= 20000) timeout("wait_done");
    endtask

    // Reference: the line level over each tick period of one frame.
    task automatic add_frame(input logic [DW-1:0] d, input int db, input int st, input int pm);
        int   n, stop_ticks;
        logic ones;
        n = (db < 5) ? 5 : ((db > DW) ? DW : db);
        repeat (OVS) exp_q.push_back(1'b0);
        ones = 1'b0;
        for (int i = 0; i < n; i++) begin
            ones ^= d[i];
            repeat (OVS) exp_q.push_back(d[i]);
        end
        case (pm)
            1: repeat (OVS) exp_q.push_back(~ones);
            2: repeat (OVS) exp_q.push_back(ones);
            3: repeat (OVS) exp_q.push_back(1'b1);
            4: repeat (OVS) exp_q.push_back(1'b0);
            default: ;
        endcase
        stop_ticks = (st == 0) ? OVS : ((st == 1) ? (3 * OVS / 2) : (2 * OVS));
        repeat (stop_ticks) exp_q.push_back(1'b1);
    endtask

    // Leading idle is skipped; the model must then match exactly, followed by idle only.
    task automatic check_stream(input string tag);
        int s, mism;
        s = obs_base;
        mism = 0;
        while (s < obs.size() && obs[s] === 1'b1) s++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (s + i >= obs.size() || obs[s + i] !== exp_q[i]) mism++;
        end
        for (int j = s + exp_q.size(); j < obs.size(); j++) begin
            if (obs[j] !== 1'b1) mism++;
        end
        total++;
        assert (mism === 0) else begin
            bad++;
            $error("FAIL %s: bad_ticks=%0d required 0 (observed %0d samples, model %0d)",
                   tag, mism, obs.size() - s, exp_q.size());
        end
    endtask

    initial begin
        logic [DW-1:0] d [9];
        logic [DW-1:0] r;
        int db, st, pm;

        m.wr_en = 1'b0; m.wr_data = '0; m.cts_n = 1'b1; m.send_break = 1'b0;
        cfg(8, 0, 0);

        // reset state
        repeat (3) step();
        chk("rst_tx", 32'(m.tx), 32'd1);
        chk("rst_busy", 32'(m.tx_busy), 32'd0);
        chk("rst_done", 32'(m.tx_done), 32'd0);
        chk("rst_level", 32'(m.fifo_level), 32'd0);
        chk("rst_empty", 32'(m.fifo_empty), 32'd1);
        chk("rst_full", 32'(m.fifo_full), 32'd0);
        rst_n = 1'b1;
        step();

        // 8N1, 0xA5
        mark();
        add_frame(9'h0A5, 8, 0, 0);
        push(9'h0A5);
        m.cts_n = 1'b0;
        wait_done(1);
        wait_ticks(20);
        check_stream("8N1_A5");
        chk("8N1_done_cnt", 32'(done_cnt - done_base), 32'd1);

        // 7 bits, odd parity, 2 stop, 0x03
        m.cts_n = 1'b1;
        cfg(7, 2, 1);
        mark();
        add_frame(9'h003, 7, 2, 1);
        push(9'h003);
        m.cts_n = 1'b0;
        wait_done(1);
        wait_ticks(20);
        check_stream("7O2_03");

        // overfill while flow-controlled, then drain back to back
        m.cts_n = 1'b1;
        cfg(8, 0, 0);
        mark();
        for (int i = 0; i < 9; i++) begin
            d[i] = 9'($urandom);
            push(d[i]);
        end
        chk("full_flag", 32'(m.fifo_full), 32'd1);
        chk("full_level", 32'(m.fifo_level), 32'(DEPTH));
        chk("full_empty", 32'(m.fifo_empty), 32'd0);
        wait_ticks(40);
        check_stream("cts_hold_idle");
        mark();
        for (int i = 0; i < 8; i++) add_frame(d[i], 8, 0, 0);
        m.cts_n = 1'b0;
        wait_done(8);
        wait_ticks(20);
        check_stream("b2b_8_frames");
        chk("b2b_done_cnt", 32'(done_cnt - done_base), 32'd8);
        chk("b2b_empty", 32'(m.fifo_empty), 32'd1);

        // 1.5 stop bits; cts and config change mid-frame
        m.cts_n = 1'b1;
        cfg(8, 1, 2);
        mark();
        d[0] = 9'($urandom);
        d[1] = 9'($urandom);
        push(d[0]);
        push(d[1]);
        add_frame(d[0], 8, 1, 2);
        m.cts_n = 1'b0;
        wait_busy();
        wait_ticks(3 * OVS);
        m.cts_n = 1'b1;
        cfg(5, 0, 1);
        wait_done(1);
        wait_ticks(40);
        check_stream("stop15_cts_mid");
        chk("cts_hold_level", 32'(m.fifo_level), 32'd1);
        chk("cts_hold_done", 32'(done_cnt - done_base), 32'd1);
        mark();
        add_frame(d[1], 5, 0, 1);
        m.cts_n = 1'b0;
        wait_done(1);
        wait_ticks(20);
        check_stream("after_cts_release");

        // break of 300 ticks with a character waiting
        m.cts_n = 1'b1;
        cfg(8, 0, 0);
        mark();
        r = 9'($urandom);
        push(r);
        m.send_break = 1'b1;
        m.cts_n = 1'b0;
        wait_busy();
        wait_ticks(299);
        m.send_break = 1'b0;
        repeat (300) exp_q.push_back(1'b0);
        repeat (OVS) exp_q.push_back(1'b1);
        add_frame(r, 8, 0, 0);
        wait_done(2);
        wait_ticks(20);
        check_stream("break_300");
        chk("break_done_cnt", 32'(done_cnt - done_base), 32'd2);

        // reset pulse mid-DATA
        m.cts_n = 1'b1;
        for (int i = 0; i < 3; i++) push(9'($urandom));
        m.cts_n = 1'b0;
        wait_busy();
        wait_ticks(40);
        rst_n = 1'b0;
        step();
        chk("midrst_tx", 32'(m.tx), 32'd1);
        chk("midrst_level", 32'(m.fifo_level), 32'd0);
        chk("midrst_busy", 32'(m.tx_busy), 32'd0);
        chk("midrst_empty", 32'(m.fifo_empty), 32'd1);
        rst_n = 1'b1;
        mark();
        wait_ticks(40);
        check_stream("post_rst_idle");

        // randomised formats, including out-of-range lengths
        for (int k = 0; k < 6; k++) begin
            db = (k == 0) ? 15 : ((k == 1) ? 2 : int'($urandom_range(0, 15)));
            st = $urandom_range(0, 3);
            pm = $urandom_range(0, 7);
            r  = 9'($urandom);
            cfg(db, st, pm);
            mark();
            add_frame(r, db, st, pm);
            push(r);
            wait_done(1);
            wait_ticks(10);
            check_stream($sformatf("rand_frame_%0d", k));
            chk($sformatf("rand_done_%0d", k), 32'(done_cnt - done_base), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
